// File: rtl/spi_adapter_pkg.sv
// spi_adapter_pkg
// Shared definitions for the SPI push/pull adapter and its response queue.
//   - adapter_state_e : adapter control states (CFG, IDLE, LAUNCH, WAIT)
//   - PUSH_BIT/PULL_BIT : flow-control bit positions for the default 34-bit
//     packet. Replies reuse the same positions for val/spc.
//   - push_bit_pos/pull_bit_pos : the same positions for any packet width,
//     so parameterised modules can stay consistent with the constants.
package spi_adapter_pkg;

   typedef enum logic [1:0] {
      CFG    = 2'd0,
      IDLE   = 2'd1,
      LAUNCH = 2'd2,
      WAIT   = 2'd3
   } adapter_state_e;

   localparam int DEFAULT_NBITS = 34;
   localparam int PUSH_BIT      = DEFAULT_NBITS - 1;
   localparam int PULL_BIT      = DEFAULT_NBITS - 2;

   // Position of push (outbound) / val (inbound) for a given packet width.
   function automatic int push_bit_pos(input int nbits);
      return nbits - 1;
   endfunction

   // Position of pull (outbound) / spc (inbound) for a given packet width.
   function automatic int pull_bit_pos(input int nbits);
      return nbits - 2;
   endfunction

endpackage

// File: rtl/spi_resp_queue_2entry.sv
// spi_resp_queue_2entry
// Two-entry val/rdy FIFO holding payloads returned by the SPI minion until
// the host takes them.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   enq_val/rdy/msg     : enqueue handshake
//   deq_val/rdy/msg     : dequeue handshake, FIFO order
//   count               : current occupancy (0..2)
module spi_resp_queue_2entry
   import spi_adapter_pkg::*;
#(
   parameter int width = DEFAULT_NBITS - 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enq_val,
   output logic             enq_rdy,
   input  logic [width-1:0] enq_msg,
   output logic             deq_val,
   input  logic             deq_rdy,
   output logic [width-1:0] deq_msg,
   output logic [1:0]       count
);

   logic [width-1:0] entries [2];
   logic             head;
   logic [1:0]       count_reg;
   logic             tail;
   logic             enq_fire;
   logic             deq_fire;

   // A full queue can still accept a new entry when the head is leaving in
   // the same cycle; the incoming word lands in the slot being vacated.
   assign enq_rdy  = (count_reg != 2'd2) || deq_rdy;
   assign deq_val  = (count_reg != 2'd0);
   assign deq_msg  = entries[head];
   assign count    = count_reg;
   assign enq_fire = enq_val && enq_rdy;
   assign deq_fire = deq_val && deq_rdy;
   assign tail     = head ^ count_reg[0];

   // Head pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         head      <= 1'b0;
         count_reg <= 2'd0;
      end else begin
         if (deq_fire) begin
            head <= ~head;
         end
         if (enq_fire && !deq_fire) begin
            count_reg <= count_reg + 2'd1;
         end else if (deq_fire && !enq_fire) begin
            count_reg <= count_reg - 2'd1;
         end
      end
   end

   // Storage is pure datapath; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (enq_fire) begin
         entries[tail] <= enq_msg;
      end
   end

endmodule

// File: rtl/spi_push_pull_adapter.sv
// spi_push_pull_adapter
// Host-side framing stage in front of the SPI master. Wraps host payloads
// into packets carrying push/pull flow-control bits, configures the master's
// packet size and chip select, retries pushes the minion did not accept and
// buffers returned payloads in a 2-entry queue.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   cs_sel, cs_sel_update      : target chip select, pulse to re-issue config
//   req_val/rdy/msg            : host request stream (nbits-2 payload)
//   resp_val/rdy/msg           : host response stream (nbits-2 payload)
//   mst_recv_val/rdy/msg       : packet to the master
//   mst_send_val/rdy/msg       : reply from the master
//   mst_pkt_size_val/rdy/msg   : master packet-size config (constant nbits)
//   mst_cs_addr_val/rdy/msg    : master chip-select config
module spi_push_pull_adapter
   import spi_adapter_pkg::*;
#(
   parameter int nbits       = 34,
   parameter int ncs         = 1,
   parameter int logBitsN    = $clog2(nbits) + 1,
   parameter int logCSN      = (ncs > 1) ? $clog2(ncs) : 1,
   parameter int POLL_CYCLES = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [logCSN-1:0]   cs_sel,
   input  logic                cs_sel_update,
   input  logic                req_val,
   output logic                req_rdy,
   input  logic [nbits-3:0]    req_msg,
   output logic                resp_val,
   input  logic                resp_rdy,
   output logic [nbits-3:0]    resp_msg,
   output logic                mst_recv_val,
   input  logic                mst_recv_rdy,
   output logic [nbits-1:0]    mst_recv_msg,
   input  logic                mst_send_val,
   output logic                mst_send_rdy,
   input  logic [nbits-1:0]    mst_send_msg,
   output logic                mst_pkt_size_val,
   input  logic                mst_pkt_size_rdy,
   output logic [logBitsN-1:0] mst_pkt_size_msg,
   output logic                mst_cs_addr_val,
   input  logic                mst_cs_addr_rdy,
   output logic [logCSN-1:0]   mst_cs_addr_msg
);

   localparam int PAYLOAD_W = nbits - 2;
   localparam int PUSH_POS  = push_bit_pos(nbits);
   localparam int PULL_POS  = pull_bit_pos(nbits);
   localparam int POLL_W    = (POLL_CYCLES > 0) ? $clog2(POLL_CYCLES + 1) : 1;
   localparam logic [POLL_W-1:0] POLL_MAX = POLL_W'(POLL_CYCLES);

   adapter_state_e       state;
   adapter_state_e       next_state;

   logic                 req_full;
   logic [PAYLOAD_W-1:0] req_data;
   logic [nbits-1:0]     pkt_reg;
   logic [POLL_W-1:0]    poll_cnt;
   logic                 cs_upd_pending;
   logic                 pkt_size_done;
   logic                 cs_addr_done;

   logic                 q_enq_val;
   logic                 q_enq_rdy;
   logic [1:0]           q_count;
   logic                 q_has_space;
   logic                 poll_due;
   logic                 launch_go;
   logic                 cfg_complete;
   logic                 send_fire;
   logic                 reply_val;
   logic                 reply_spc;

   assign q_has_space  = (q_count != 2'd2);
   assign poll_due     = (POLL_CYCLES != 0) && (poll_cnt == POLL_MAX);
   assign launch_go    = req_full || (poll_due && q_has_space);
   assign cfg_complete = (pkt_size_done || mst_pkt_size_rdy) &&
                         (cs_addr_done  || mst_cs_addr_rdy);
   assign send_fire    = (state == WAIT) && mst_send_val;
   assign reply_val    = mst_send_msg[PUSH_POS];
   assign reply_spc    = mst_send_msg[PULL_POS];

   assign req_rdy          = !req_full;
   assign mst_recv_msg     = pkt_reg;
   assign mst_pkt_size_msg = logBitsN'(nbits);
   assign mst_cs_addr_msg  = cs_sel;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= CFG;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. A pending chip-select change always wins over a
   // launch so config never overlaps an outgoing packet.
   always_comb begin
      next_state = state;
      unique case (state)
         CFG: begin
            if (cfg_complete) next_state = IDLE;
         end
         IDLE: begin
            if (cs_upd_pending) next_state = CFG;
            else if (launch_go) next_state = LAUNCH;
         end
         LAUNCH: begin
            if (mst_recv_rdy) next_state = WAIT;
         end
         WAIT: begin
            if (mst_send_val) next_state = IDLE;
         end
         default: next_state = CFG;
      endcase
   end

   // Output decode. Each config channel drops its val once its own
   // handshake has completed, in case the master's two rdys differ.
   always_comb begin
      mst_recv_val     = 1'b0;
      mst_send_rdy     = 1'b0;
      mst_pkt_size_val = 1'b0;
      mst_cs_addr_val  = 1'b0;
      unique case (state)
         CFG: begin
            mst_pkt_size_val = !pkt_size_done;
            mst_cs_addr_val  = !cs_addr_done;
         end
         LAUNCH: mst_recv_val = 1'b1;
         WAIT:   mst_send_rdy = 1'b1;
         default: ;
      endcase
   end

   // Request holding register, frozen packet, poll counter, pending config
   // flag and per-channel config completion. A push is retired only when
   // the minion reports it accepted the payload; otherwise it is re-sent.
   always_ff @(posedge clk) begin
      if (reset) begin
         req_full       <= 1'b0;
         req_data       <= '0;
         pkt_reg        <= '0;
         poll_cnt       <= '0;
         cs_upd_pending <= 1'b0;
         pkt_size_done  <= 1'b0;
         cs_addr_done   <= 1'b0;
      end else begin
         if (send_fire && pkt_reg[PUSH_POS] && reply_spc) begin
            req_full <= 1'b0;
         end else if (req_val && !req_full) begin
            req_full <= 1'b1;
            req_data <= req_msg;
         end

         if ((state == IDLE) && (next_state == LAUNCH)) begin
            pkt_reg <= {req_full, q_has_space, (req_full ? req_data : '0)};
         end

         if (state == LAUNCH) begin
            poll_cnt <= '0;
         end else if ((state == IDLE) && (next_state == IDLE) &&
                      (poll_cnt != POLL_MAX)) begin
            poll_cnt <= poll_cnt + 1'b1;
         end

         if (cs_sel_update) begin
            cs_upd_pending <= 1'b1;
         end else if (state == CFG) begin
            cs_upd_pending <= 1'b0;
         end

         if (state != CFG) begin
            pkt_size_done <= 1'b0;
            cs_addr_done  <= 1'b0;
         end else begin
            if (mst_pkt_size_rdy) pkt_size_done <= 1'b1;
            if (mst_cs_addr_rdy)  cs_addr_done  <= 1'b1;
         end
      end
   end

   // Replies with val=0 carry no payload and are dropped.
   assign q_enq_val = send_fire && reply_val && q_enq_rdy;

   spi_resp_queue_2entry #(
      .width (PAYLOAD_W)
   ) u_resp_queue (
      .clk     (clk),
      .reset   (reset),
      .enq_val (q_enq_val),
      .enq_rdy (q_enq_rdy),
      .enq_msg (mst_send_msg[PAYLOAD_W-1:0]),
      .deq_val (resp_val),
      .deq_rdy (resp_rdy),
      .deq_msg (resp_msg),
      .count   (q_count)
   );

endmodule

// File: tb/tb_spi_push_pull_adapter.sv
// tb_spi_push_pull_adapter
// Self-checking bench for spi_push_pull_adapter. The bench plays the SPI
// master: it serves config and packet handshakes, returns scripted replies,
// and compares launched packets and host responses against scoreboards.
module tb_spi_push_pull_adapter;

   localparam int NBITS    = 34;
   localparam int NCS      = 2;
   localparam int LOGBITSN = $clog2(NBITS) + 1;
   localparam int LOGCSN   = 1;
   localparam int POLL     = 16;

   logic                clk;
   logic                reset;
   logic [LOGCSN-1:0]   cs_sel;
   logic                cs_sel_update;
   logic                req_val;
   logic                req_rdy;
   logic [NBITS-3:0]    req_msg;
   logic                resp_val;
   logic                resp_rdy;
   logic [NBITS-3:0]    resp_msg;
   logic                mst_recv_val;
   logic                mst_recv_rdy;
   logic [NBITS-1:0]    mst_recv_msg;
   logic                mst_send_val;
   logic                mst_send_rdy;
   logic [NBITS-1:0]    mst_send_msg;
   logic                mst_pkt_size_val;
   logic                mst_pkt_size_rdy;
   logic [LOGBITSN-1:0] mst_pkt_size_msg;
   logic                mst_cs_addr_val;
   logic                mst_cs_addr_rdy;
   logic [LOGCSN-1:0]   mst_cs_addr_msg;

   int checkCount = 0;
   int errorCount = 0;

   logic [NBITS-1:0] expPkt [$];
   logic [NBITS-3:0] expResp [$];

   spi_push_pull_adapter #(
      .nbits       (NBITS),
      .ncs         (NCS),
      .logBitsN    (LOGBITSN),
      .logCSN      (LOGCSN),
      .POLL_CYCLES (POLL)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .cs_sel           (cs_sel),
      .cs_sel_update    (cs_sel_update),
      .req_val          (req_val),
      .req_rdy          (req_rdy),
      .req_msg          (req_msg),
      .resp_val         (resp_val),
      .resp_rdy         (resp_rdy),
      .resp_msg         (resp_msg),
      .mst_recv_val     (mst_recv_val),
      .mst_recv_rdy     (mst_recv_rdy),
      .mst_recv_msg     (mst_recv_msg),
      .mst_send_val     (mst_send_val),
      .mst_send_rdy     (mst_send_rdy),
      .mst_send_msg     (mst_send_msg),
      .mst_pkt_size_val (mst_pkt_size_val),
      .mst_pkt_size_rdy (mst_pkt_size_rdy),
      .mst_pkt_size_msg (mst_pkt_size_msg),
      .mst_cs_addr_val  (mst_cs_addr_val),
      .mst_cs_addr_rdy  (mst_cs_addr_rdy),
      .mst_cs_addr_msg  (mst_cs_addr_msg)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Response scoreboard and config/launch exclusivity, sampled mid-cycle
   // so the values seen are the ones the next rising edge will act on.
   always @(negedge clk) begin
      if (!reset && resp_val && resp_rdy) begin
         if (expResp.size() == 0) begin
            checkOutput("respUnexpected", {63'd0, resp_val}, 64'd0);
         end else begin
            checkOutput("respMsg", resp_msg, expResp.pop_front());
         end
      end
      if (!reset && mst_pkt_size_val) begin
         checkOutput("cfgNoRecv", mst_recv_val, 64'd0);
      end
   end

   // Host side: present one request and wait for it to be taken; the
   // packet it should produce goes on the packet scoreboard.
   task automatic sendRequest(input logic [NBITS-3:0] payload, input logic pull);
      int waited;
      waited  = 0;
      req_msg = payload;
      req_val = 1'b1;
      while (!req_rdy && waited < 200) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!req_rdy) begin
         checkOutput("reqAcceptTimeout", req_rdy, 64'd1);
         req_val = 1'b0;
      end else begin
         @(posedge clk); #1;
         req_val = 1'b0;
         expPkt.push_back({1'b1, pull, payload});
      end
   endtask

   // Master side: wait for a launched packet, compare it, then return the
   // given reply during WAIT (optionally pulsing cs_sel_update alongside).
   task automatic applyStimulus(input logic [NBITS-1:0] reply, input logic pulseCs,
                                output int waited);
      waited = 0;
      while (!mst_recv_val && waited < 200) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!mst_recv_val) begin
         checkOutput("launchTimeout", mst_recv_val, 64'd1);
         return;
      end
      if (expPkt.size() == 0) begin
         checkOutput("pktUnexpected", {63'd0, mst_recv_val}, 64'd0);
      end else begin
         checkOutput("recvMsg", mst_recv_msg, expPkt.pop_front());
      end
      checkOutput("sendRdyInLaunch", mst_send_rdy, 64'd0);
      @(posedge clk); #1;
      checkOutput("sendRdyInWait", mst_send_rdy, 64'd1);
      checkOutput("recvValInWait", mst_recv_val, 64'd0);
      mst_send_val  = 1'b1;
      mst_send_msg  = reply;
      cs_sel_update = pulseCs;
      if (reply[NBITS-1]) expResp.push_back(reply[NBITS-3:0]);
      @(posedge clk); #1;
      mst_send_val  = 1'b0;
      cs_sel_update = 1'b0;
   endtask

   // Wait for a config phase and check what it presents to the master.
   task automatic waitCfg(input logic [LOGCSN-1:0] expCs);
      int waited;
      waited = 0;
      while (!mst_pkt_size_val && waited < 50) begin
         @(posedge clk); #1;
         waited++;
      end
      checkOutput("cfgSeen", mst_pkt_size_val, 64'd1);
      checkOutput("cfgPktSize", mst_pkt_size_msg, 64'd34);
      checkOutput("cfgCsVal", mst_cs_addr_val, 64'd1);
      checkOutput("cfgCsAddr", mst_cs_addr_msg, expCs);
      checkOutput("cfgNoRecvVal", mst_recv_val, 64'd0);
      @(posedge clk); #1;
      checkOutput("cfgDone", mst_pkt_size_val, 64'd0);
      checkOutput("cfgCsDone", mst_cs_addr_val, 64'd0);
   endtask

   // Hard time limit so a stuck design still ends the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete, errors so far %0d", errorCount);
      $fatal(1, "[TB] watchdog expired");
   end

   // Main test sequence.
   initial begin
      int w;
      reset            = 1'b1;
      cs_sel           = '0;
      cs_sel_update    = 1'b0;
      req_val          = 1'b0;
      req_msg          = '0;
      resp_rdy         = 1'b1;
      mst_recv_rdy     = 1'b1;
      mst_send_val     = 1'b0;
      mst_send_msg     = '0;
      mst_pkt_size_rdy = 1'b1;
      mst_cs_addr_rdy  = 1'b1;

      // Reset state: CFG presenting size 34 and cs 0, nothing else active.
      $display("[TB] reset");
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rstRecvVal", mst_recv_val, 64'd0);
      checkOutput("rstSendRdy", mst_send_rdy, 64'd0);
      checkOutput("rstRespVal", resp_val, 64'd0);
      checkOutput("rstReqRdy", req_rdy, 64'd1);
      reset = 1'b0;
      waitCfg(1'b0);

      // Push with accept, no returned payload.
      $display("[TB] single push");
      sendRequest(32'h12345678, 1'b1);
      applyStimulus(34'h1_00000000, 1'b0, w);
      checkOutput("pushReqRdy", req_rdy, 64'd1);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("pushRespVal", resp_val, 64'd0);

      // Rejected push is re-sent unchanged, then retired.
      $display("[TB] retry");
      sendRequest(32'hA5A5A5A5, 1'b1);
      expPkt.push_back(34'h3_A5A5A5A5);
      applyStimulus(34'h0_00000000, 1'b0, w);
      checkOutput("retryHeld", req_rdy, 64'd0);
      applyStimulus(34'h1_00000000, 1'b0, w);
      checkOutput("retryCleared", req_rdy, 64'd1);

      // Idle poll: pull-only packet after the poll interval.
      $display("[TB] poll");
      expPkt.push_back(34'h1_00000000);
      applyStimulus(34'h2_DEADBEEF, 1'b0, w);
      checkOutput("pollNotEarly", (w >= POLL) && (w <= POLL + 2), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("pollDrained", resp_val, 64'd0);

      // Full response queue suppresses pull until the host pops one.
      $display("[TB] backpressure");
      resp_rdy = 1'b0;
      sendRequest(32'h11111111, 1'b1);
      applyStimulus(34'h3_0000AAAA, 1'b0, w);
      sendRequest(32'h22222222, 1'b1);
      applyStimulus(34'h3_0000BBBB, 1'b0, w);
      sendRequest(32'h33333333, 1'b0);
      applyStimulus(34'h1_00000000, 1'b0, w);
      checkOutput("fullRespVal", resp_val, 64'd1);
      checkOutput("fullHead", resp_msg, 64'h0000AAAA);
      resp_rdy = 1'b1;
      @(posedge clk); #1;
      resp_rdy = 1'b0;
      sendRequest(32'h44444444, 1'b1);
      applyStimulus(34'h1_00000000, 1'b0, w);
      resp_rdy = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("bpDrained", resp_val, 64'd0);

      // Chip-select change during WAIT forces a config before next launch.
      $display("[TB] cs update");
      cs_sel = 1'b1;
      sendRequest(32'h55555555, 1'b1);
      applyStimulus(34'h1_00000000, 1'b1, w);
      sendRequest(32'h66666666, 1'b1);
      waitCfg(1'b1);
      applyStimulus(34'h1_00000000, 1'b0, w);

      repeat (3) @(posedge clk);
      #1;
      checkOutput("pktScoreboardEmpty", expPkt.size(), 64'd0);
      checkOutput("respScoreboardEmpty", expResp.size(), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
